// File: rtl/seg_scan_capture.sv
// rtl/seg_scan_capture.sv - monitor for a multiplexed 7-segment SEG/AN bus, publishes debounced decoded frames
module seg_scan_capture #(
    parameter int DIGITS        = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            SEG,
    input  logic [DIGITS-1:0]     AN,
    input  logic                  clear_err,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     blank,
    output logic                  frame_valid,
    output logic                  value_changed,
    output logic [15:0]           frame_count,
    output logic                  seg_err,
    output logic                  an_err
);

    localparam int HW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int LW = $clog2(DIGITS + 1);
    localparam logic [HW-1:0]     HOLD_MAX = HW'(STABLE_CYCLES - 1);
    localparam logic [HW-1:0]     HOLD_ACC = HW'(STABLE_CYCLES - 2);
    localparam logic [DIGITS-1:0] ALL_SEEN = '1;

    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

    state_t                state;
    logic [DIGITS+7:0]     s_q;
    logic [DIGITS+7:0]     sample;
    logic [HW-1:0]         hold_cnt;
    logic [DIGITS-1:0]     seen;
    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dp;
    logic [DIGITS-1:0]     shadow_blank;

    logic                  match;
    logic                  stable_hit;
    logic [LW-1:0]         low_cnt;
    logic [IW-1:0]         an_idx;
    logic                  acc_digit;
    logic                  acc_multi;
    logic [4:0]            dec;
    logic                  is_blank;
    logic                  bad_seg;
    logic [DIGITS-1:0]     seen_acc;
    logic [DIGITS-1:0]     seen_next;

    // {valid, nibble} for an active-low a..g pattern
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    assign sample     = {AN, SEG};
    assign match      = (sample == s_q);
    // hold_cnt counts repeats beyond the first sample, so this edge completes the STABLE_CYCLES-th sample
    assign stable_hit = match && (hold_cnt == HOLD_ACC);

    always_comb begin
        low_cnt = '0;
        an_idx  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!AN[i]) begin
                low_cnt = low_cnt + 1'b1;
                an_idx  = IW'(i);
            end
        end
    end

    assign acc_digit = stable_hit && (low_cnt == LW'(1));
    assign acc_multi = stable_hit && (low_cnt > LW'(1));
    assign dec       = decode(SEG[6:0]);
    assign is_blank  = (SEG[6:0] == 7'h7F);
    assign bad_seg   = !dec[4] && !is_blank;
    assign seen_acc  = acc_digit ? (DIGITS'(1) << an_idx) : '0;
    assign seen_next = seen | seen_acc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            s_q           <= '0;
            hold_cnt      <= '0;
            seen          <= '0;
            shadow_val    <= '0;
            shadow_dp     <= '0;
            shadow_blank  <= '0;
            value         <= '0;
            dp            <= '0;
            blank         <= '0;
            frame_valid   <= 1'b0;
            value_changed <= 1'b0;
            frame_count   <= '0;
            seg_err       <= 1'b0;
            an_err        <= 1'b0;
        end else begin
            s_q <= sample;
            if (!match)
                hold_cnt <= '0;
            else if (hold_cnt != HOLD_MAX)
                hold_cnt <= hold_cnt + 1'b1;

            frame_valid   <= 1'b0;
            value_changed <= 1'b0;

            if (acc_digit) begin
                shadow_val[{an_idx, 2'b00} +: 4] <= dec[3:0];
                shadow_dp[an_idx]                <= ~SEG[7];
                shadow_blank[an_idx]             <= is_blank;
            end

            // a new error in the same cycle as clear_err keeps the flag set
            if (acc_digit && bad_seg)
                seg_err <= 1'b1;
            else if (clear_err)
                seg_err <= 1'b0;
            if (acc_multi)
                an_err <= 1'b1;
            else if (clear_err)
                an_err <= 1'b0;

            unique case (state)
                IDLE: begin
                    seen <= seen_next;
                    if (acc_digit)
                        state <= (seen_next == ALL_SEEN) ? PUBLISH : COLLECT;
                end
                COLLECT: begin
                    seen <= seen_next;
                    if (seen_next == ALL_SEEN)
                        state <= PUBLISH;
                end
                PUBLISH: begin
                    // shadow still holds the completed frame; this cycle's accept starts the next one
                    value         <= shadow_val;
                    dp            <= shadow_dp;
                    blank         <= shadow_blank;
                    frame_valid   <= 1'b1;
                    value_changed <= (shadow_val != value);
                    frame_count   <= frame_count + 16'd1;
                    seen          <= seen_acc;
                    state         <= (seen_acc == ALL_SEEN) ? PUBLISH : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb/tb_seg_scan_capture.sv - randomized bench for seg_scan_capture against a sample-run reference model
module tb_seg_scan_capture;

    localparam int DIGITS = 8;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  SEG = 8'hFF;
    logic [7:0]  AN  = 8'hFF;
    logic        clear_err = 1'b0;
    logic [31:0] value;
    logic [7:0]  dp;
    logic [7:0]  blank;
    logic        frame_valid;
    logic        value_changed;
    logic [15:0] frame_count;
    logic        seg_err;
    logic        an_err;

    seg_scan_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .rst(rst), .SEG(SEG), .AN(AN), .clear_err(clear_err),
        .value(value), .dp(dp), .blank(blank), .frame_valid(frame_valid),
        .value_changed(value_changed), .frame_count(frame_count),
        .seg_err(seg_err), .an_err(an_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int fv_cnt   = 0;
    logic last_vc = 1'b0;

    logic [6:0] pat_tab [16];

    // reference model state: the model only sees the input sequence and the display rules
    logic [15:0] m_last;
    int          m_run;
    logic [31:0] m_sh_val, m_val;
    logic [7:0]  m_sh_dp, m_sh_blank, m_dp, m_blank, m_seen;
    logic        m_pend, m_fv, m_vc, m_seg_err, m_an_err;
    logic [15:0] m_fc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_last = '0; m_run = 1;
        m_sh_val = '0; m_val = '0; m_sh_dp = '0; m_sh_blank = '0;
        m_dp = '0; m_blank = '0; m_seen = '0; m_pend = 0; m_fv = 0; m_vc = 0;
        m_seg_err = 0; m_an_err = 0; m_fc = '0;
    endtask

    task automatic model_edge(input logic [7:0] an, input logic [7:0] seg, input logic clr);
        logic [15:0] cur;
        int zeros, idx, nib;
        logic new_seg, new_an;
        cur = {an, seg};
        if (cur == m_last) m_run++; else m_run = 1;
        m_last = cur;
        m_fv = 0; m_vc = 0; new_seg = 0; new_an = 0;
        if (m_pend) begin
            m_vc = (m_sh_val != m_val);
            m_val = m_sh_val; m_dp = m_sh_dp; m_blank = m_sh_blank;
            m_fv = 1; m_fc = m_fc + 16'd1; m_seen = '0; m_pend = 0;
        end
        if (m_run == STABLE) begin
            zeros = 0; idx = 0;
            for (int i = 0; i < DIGITS; i++) if (!an[i]) begin zeros++; idx = i; end
            if (zeros == 1) begin
                nib = -1;
                for (int k = 0; k < 16; k++) if (pat_tab[k] == seg[6:0]) nib = k;
                m_sh_blank[idx] = (seg[6:0] == 7'h7F);
                if (nib < 0) begin
                    nib = 0;
                    if (seg[6:0] != 7'h7F) new_seg = 1;
                end
                m_sh_val[idx*4 +: 4] = nib[3:0];
                m_sh_dp[idx] = ~seg[7];
                m_seen[idx] = 1'b1;
                if (m_seen == 8'hFF) m_pend = 1;
            end else if (zeros > 1) begin
                new_an = 1;
            end
        end
        if (clr) begin m_seg_err = 0; m_an_err = 0; end
        if (new_seg) m_seg_err = 1;
        if (new_an)  m_an_err  = 1;
    endtask

    task automatic compare_all();
        check_eq("frame_valid", frame_valid, m_fv);
        check_eq("value_changed", value_changed, m_vc);
        check_eq("value", value, m_val);
        check_eq("dp", dp, m_dp);
        check_eq("blank", blank, m_blank);
        check_eq("frame_count", frame_count, m_fc);
        check_eq("seg_err", seg_err, m_seg_err);
        check_eq("an_err", an_err, m_an_err);
    endtask

    task automatic step(input logic [7:0] an, input logic [7:0] seg, input logic clr);
        AN = an; SEG = seg; clear_err = clr;
        @(posedge clk);
        model_edge(an, seg, clr);
        #1;
        if (frame_valid) begin fv_cnt++; last_vc = value_changed; end
        compare_all();
    endtask

    task automatic hold_digit(input int idx, input logic [7:0] seg, input int cycles);
        logic [7:0] an;
        an = ~(8'h01 << idx);
        for (int c = 0; c < cycles; c++) step(an, seg, 1'b0);
    endtask

    task automatic scan_frame(input logic [63:0] segs, input int cycles);
        for (int i = 0; i < DIGITS; i++) hold_digit(i, segs[i*8 +: 8], cycles);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #2;
        model_reset();
        compare_all();
        check_eq("reset_value", value, 32'h0);
        check_eq("reset_fcount", frame_count, 16'h0);
        AN = 8'hFF; SEG = 8'hFF; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    logic [63:0] base_segs;
    logic [63:0] fsegs;
    int f0;

    initial begin
        pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        base_segs = {8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        #3;
        do_reset();

        // 1: plain scan of 87654321
        f0 = fv_cnt;
        scan_frame(base_segs, 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t1_frames", fv_cnt - f0, 1);
        check_eq("t1_value", value, 32'h87654321);
        check_eq("t1_fcount", frame_count, 16'd1);
        check_eq("t1_errs", {seg_err, an_err}, 2'b00);

        // 2: a too-short digit blocks the frame until it is held long enough
        f0 = fv_cnt;
        for (int i = 0; i < DIGITS; i++)
            hold_digit(i, base_segs[i*8 +: 8], (i == 3) ? 3 : 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t2_noframe", fv_cnt - f0, 0);
        hold_digit(3, base_segs[31:24], 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t2_frame", fv_cnt - f0, 1);

        // 3: undecodable pattern on digit 2
        fsegs = base_segs;
        fsegs[23:16] = 8'hF7;
        scan_frame(fsegs, 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t3_seg_err", seg_err, 1'b1);
        check_eq("t3_nibble", value[11:8], 4'h0);
        step(8'hFF, 8'hFF, 1'b1);
        check_eq("t3_cleared", seg_err, 1'b0);

        // 4: multiple anodes low, then a dark digit
        f0 = fv_cnt;
        for (int c = 0; c < 10; c++) step(8'hF0, 8'hF9, 1'b0);
        check_eq("t4_an_err", an_err, 1'b1);
        check_eq("t4_noframe", fv_cnt - f0, 0);
        fsegs = base_segs;
        fsegs[47:40] = 8'hFF;
        scan_frame(fsegs, 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t4_blank", blank[5], 1'b1);
        check_eq("t4_seg_err", seg_err, 1'b0);
        step(8'hFF, 8'hFF, 1'b1);

        // 5: reset in the middle of a frame
        for (int i = 0; i < 5; i++) hold_digit(i, base_segs[i*8 +: 8], 10);
        do_reset();
        f0 = fv_cnt;
        for (int i = 0; i < 7; i++) hold_digit(i, base_segs[i*8 +: 8], 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t5_partial", fv_cnt - f0, 0);
        hold_digit(7, base_segs[63:56], 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t5_full", fv_cnt - f0, 1);
        check_eq("t5_vc_first", last_vc, 1'b1);

        // 6: identical frame, then one digit changed
        scan_frame(base_segs, 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t6_same_vc", last_vc, 1'b0);
        fsegs = base_segs;
        fsegs[7:0] = 8'h88;
        scan_frame(fsegs, 10);
        step(8'hFF, 8'hFF, 1'b0);
        check_eq("t6_diff_vc", last_vc, 1'b1);
        check_eq("t6_nibble", value[3:0], 4'hA);

        // random bus activity: glitches, short holds, gaps, bad patterns, multi-low anodes
        for (int n = 0; n < 400; n++) begin
            int kind, idx, len;
            logic [7:0] seg, an;
            kind = $urandom_range(0, 19);
            idx  = $urandom_range(0, DIGITS - 1);
            len  = $urandom_range(1, 8);
            seg  = {1'($urandom_range(0, 1)), pat_tab[$urandom_range(0, 15)]};
            an   = ~(8'h01 << idx);
            if (kind == 0) seg = 8'($urandom);
            if (kind == 1) seg = {1'b1, 7'h7F};
            if (kind == 2) an = 8'($urandom);
            if (kind == 3) an = 8'hFF;
            for (int c = 0; c < len; c++)
                step(an, seg, ($urandom_range(0, 29) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
